dll_fetcher: RTL and testbench

DLL_FETCHER -- requirements
Module: dll_fetcher

---
 rtl/dll_fetcher.sv | 202 ++++++++++++++++++++
 tb/tb_dll_fetcher.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dll_fetcher.sv
// -----------------------------------------------------------------------------
// dll_fetcher
//
// Walks the display-list-list (DLL) in memory. Each DLL entry is three bytes:
//   byte0: bit7 DLI, bit6 holey16, bit5 holey8, bit4 unused, bits3:0 offset
//   byte1: display-list address high byte
//   byte2: display-list address low byte
// A qualified frame_start loads the DLL pointer from ZP and fetches the first
// entry. Each line_start then counts the zone offset down. When the offset is
// already zero, line_start fetches the next entry.
//
// Memory handshake: mem_req/mem_addr form a request that stays asserted, with
// a stable address, until mem_ack is sampled high on a rising edge while
// mem_req is high. mem_data is valid in that same cycle. mem_ack seen while
// mem_req is low carries no meaning and is dropped. After every accepted byte,
// and on every entry into a fetch, mem_req is held low for one cycle.
//
// Ports:
//   sysclock, reset     clock and asynchronous active-high reset
//   ZP, zp_written      DLL base address and its "both bytes written" flag
//   dma_en              DMA enable; low forces IDLE
//   frame_start         first visible line of a frame (restarts at ZP)
//   line_start          start of each visible line
//   mem_req, mem_addr   read request and address
//   mem_ack, mem_data   read completion and data
//   dl_ptr, dl_offset   current display-list address and zone line offset
//   holey, dli          {holey16, holey8} and the qualified DLI flag
//   dl_valid            dl_ptr/dl_offset/holey/dli are valid
//   overrun             sticky: line_start arrived during a fetch
// -----------------------------------------------------------------------------
module dll_fetcher (
    input  logic        sysclock,
    input  logic        reset,
    input  logic [15:0] ZP,
    input  logic        zp_written,
    input  logic        dma_en,
    input  logic        frame_start,
    input  logic        line_start,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [15:0] dl_ptr,
    output logic [3:0]  dl_offset,
    output logic [1:0]  holey,
    output logic        dli,
    output logic        dl_valid,
    output logic        overrun
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH0 = 3'd1,
        FETCH1 = 3'd2,
        FETCH2 = 3'd3,
        ACTIVE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] dll_ptr_q, dll_ptr_d;
    // Set for the first cycle of every fetch state so mem_req returns low
    // between bytes and after an abort/restart.
    logic        gap_q, gap_d;
    // byte0 with the unused bit 4 dropped: {dli, holey16, holey8, offset}
    logic [6:0]  byte0_q, byte0_d;
    logic [7:0]  byte1_q, byte1_d;
    logic [15:0] dl_ptr_q, dl_ptr_d;
    logic [3:0]  dl_offset_q, dl_offset_d;
    logic [1:0]  holey_q, holey_d;
    logic        dli_flag_q, dli_flag_d;
    logic        dl_valid_q, dl_valid_d;
    logic        overrun_q, overrun_d;

    logic        fetching;
    logic        req;
    logic        ack_ok;
    logic        frame_ok;

    assign fetching = (state_q == FETCH0) || (state_q == FETCH1) || (state_q == FETCH2);
    // Built only from flops, so reset removes the request asynchronously.
    assign req      = fetching && !gap_q;
    assign ack_ok   = req && mem_ack;
    assign frame_ok = frame_start && zp_written;

    always_comb begin
        state_d     = state_q;
        dll_ptr_d   = dll_ptr_q;
        gap_d       = 1'b0;
        byte0_d     = byte0_q;
        byte1_d     = byte1_q;
        dl_ptr_d    = dl_ptr_q;
        dl_offset_d = dl_offset_q;
        holey_d     = holey_q;
        dli_flag_d  = dli_flag_q;
        dl_valid_d  = dl_valid_q;
        overrun_d   = overrun_q;

        if (!dma_en) begin
            // Display data outputs hold; only the valid flag and request drop.
            state_d    = IDLE;
            dl_valid_d = 1'b0;
        end else if (frame_ok) begin
            // Restart from any state; wins over a coincident line_start.
            state_d    = FETCH0;
            dll_ptr_d  = ZP;
            gap_d      = 1'b1;
            dl_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                FETCH0: begin
                    if (line_start) overrun_d = 1'b1;
                    if (ack_ok) begin
                        byte0_d   = {mem_data[7:5], mem_data[3:0]};
                        dll_ptr_d = dll_ptr_q + 16'd1;
                        gap_d     = 1'b1;
                        state_d   = FETCH1;
                    end
                end
                FETCH1: begin
                    if (line_start) overrun_d = 1'b1;
                    if (ack_ok) begin
                        byte1_d   = mem_data;
                        dll_ptr_d = dll_ptr_q + 16'd1;
                        gap_d     = 1'b1;
                        state_d   = FETCH2;
                    end
                end
                FETCH2: begin
                    if (line_start) overrun_d = 1'b1;
                    if (ack_ok) begin
                        dll_ptr_d   = dll_ptr_q + 16'd1;
                        dl_ptr_d    = {byte1_q, mem_data};
                        dl_offset_d = byte0_q[3:0];
                        holey_d     = byte0_q[5:4];
                        dli_flag_d  = byte0_q[6];
                        dl_valid_d  = 1'b1;
                        state_d     = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (line_start) begin
                        if (dl_offset_q != 4'd0) begin
                            dl_offset_d = dl_offset_q - 4'd1;
                        end else begin
                            // Zone finished: DLL pointer already sits on the
                            // next entry.
                            dl_valid_d = 1'b0;
                            gap_d      = 1'b1;
                            state_d    = FETCH0;
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    dl_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge sysclock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            dll_ptr_q   <= 16'h0000;
            gap_q       <= 1'b0;
            byte0_q     <= 7'h00;
            byte1_q     <= 8'h00;
            dl_ptr_q    <= 16'h0000;
            dl_offset_q <= 4'h0;
            holey_q     <= 2'b00;
            dli_flag_q  <= 1'b0;
            dl_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dll_ptr_q   <= dll_ptr_d;
            gap_q       <= gap_d;
            byte0_q     <= byte0_d;
            byte1_q     <= byte1_d;
            dl_ptr_q    <= dl_ptr_d;
            dl_offset_q <= dl_offset_d;
            holey_q     <= holey_d;
            dli_flag_q  <= dli_flag_d;
            dl_valid_q  <= dl_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mem_req   = req;
    assign mem_addr  = dll_ptr_q;
    assign dl_ptr    = dl_ptr_q;
    assign dl_offset = dl_offset_q;
    assign holey     = holey_q;
    assign dli       = dli_flag_q && (dl_offset_q == 4'd0) && dl_valid_q;
    assign dl_valid  = dl_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_dll_fetcher.sv
// -----------------------------------------------------------------------------
// tb_dll_fetcher: directed bench for dll_fetcher. Inputs change and outputs
// are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dll_fetcher;

    logic        sysclock = 1'b0;
    logic        reset;
    logic [15:0] ZP;
    logic        zp_written;
    logic        dma_en;
    logic        frame_start;
    logic        line_start;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic [15:0] dl_ptr;
    logic [3:0]  dl_offset;
    logic [1:0]  holey;
    logic        dli;
    logic        dl_valid;
    logic        overrun;

    int tests_run    = 0;
    int tests_failed = 0;

    dll_fetcher dut (
        .sysclock    (sysclock),
        .reset       (reset),
        .ZP          (ZP),
        .zp_written  (zp_written),
        .dma_en      (dma_en),
        .frame_start (frame_start),
        .line_start  (line_start),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .dl_ptr      (dl_ptr),
        .dl_offset   (dl_offset),
        .holey       (holey),
        .dli         (dli),
        .dl_valid    (dl_valid),
        .overrun     (overrun)
    );

    always #5 sysclock = ~sysclock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge sysclock);
    endtask

    task automatic pulse_frame(input logic with_line);
        frame_start = 1'b1;
        line_start  = with_line;
        tick();
        frame_start = 1'b0;
        line_start  = 1'b0;
    endtask

    task automatic pulse_line();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    // Waits (bounded) for a request, checks its address, then acks it for
    // one cycle and checks the request drops afterwards.
    task automatic serve_byte(input string tag, input logic [15:0] addr, input logic [7:0] data);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        check({tag, "_addr"}, {16'd0, mem_addr}, {16'd0, addr});
        mem_ack  = 1'b1;
        mem_data = data;
        tick();
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        check({tag, "_gap"}, {31'd0, mem_req}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"},   {31'd0, mem_req},   32'd0);
        check({tag, "_mem_addr"},  {16'd0, mem_addr},  32'd0);
        check({tag, "_dl_ptr"},    {16'd0, dl_ptr},    32'd0);
        check({tag, "_dl_offset"}, {28'd0, dl_offset}, 32'd0);
        check({tag, "_holey"},     {30'd0, holey},     32'd0);
        check({tag, "_dli"},       {31'd0, dli},       32'd0);
        check({tag, "_dl_valid"},  {31'd0, dl_valid},  32'd0);
        check({tag, "_overrun"},   {31'd0, overrun},   32'd0);
    endtask

    initial begin
        // ---- reset ----
        reset       = 1'b1;
        ZP          = 16'h1820;
        zp_written  = 1'b0;
        dma_en      = 1'b1;
        frame_start = 1'b0;
        line_start  = 1'b0;
        mem_ack     = 1'b0;
        mem_data    = 8'h00;
        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();

        // ---- guard: frame_start without zp_written ----
        pulse_frame(1'b0);
        for (int i = 0; i < 4; i++) begin
            check("no_req_zpw0", {31'd0, mem_req}, 32'd0);
            tick();
        end

        // ---- basic fetch ----
        zp_written = 1'b1;
        pulse_frame(1'b0);
        check("f0_entry_gap", {31'd0, mem_req}, 32'd0);
        serve_byte("basic_b0", 16'h1820, 8'h8F);
        serve_byte("basic_b1", 16'h1821, 8'h40);
        serve_byte("basic_b2", 16'h1822, 8'h00);
        check("basic_dl_ptr",   {16'd0, dl_ptr},    32'h4000);
        check("basic_offset",   {28'd0, dl_offset}, 32'd15);
        check("basic_holey",    {30'd0, holey},     32'd0);
        check("basic_dli",      {31'd0, dli},       32'd0);
        check("basic_dl_valid", {31'd0, dl_valid},  32'd1);
        check("basic_overrun",  {31'd0, overrun},   32'd0);

        // ---- zone countdown ----
        for (int i = 0; i < 15; i++) begin
            pulse_line();
            check("cnt_offset", {28'd0, dl_offset}, 32'(14 - i));
            check("cnt_no_req", {31'd0, mem_req}, 32'd0);
        end
        check("cnt_dli",   {31'd0, dli},      32'd1);
        check("cnt_valid", {31'd0, dl_valid}, 32'd1);
        pulse_line();
        check("z16_valid", {31'd0, dl_valid}, 32'd0);
        check("z16_dli",   {31'd0, dli},      32'd0);
        serve_byte("z16_b0", 16'h1823, 8'h02);

        // ---- overrun: line_start during FETCH1 ----
        pulse_line();
        check("ovr_set", {31'd0, overrun}, 32'd1);
        serve_byte("z16_b1", 16'h1824, 8'h50);
        serve_byte("z16_b2", 16'h1825, 8'h00);
        check("z16_dl_ptr", {16'd0, dl_ptr},    32'h5000);
        check("z16_offset", {28'd0, dl_offset}, 32'd2);
        check("z16_vld",    {31'd0, dl_valid},  32'd1);
        check("ovr_held",   {31'd0, overrun},   32'd1);
        pulse_line();
        check("z16_dec",    {28'd0, dl_offset}, 32'd1);
        check("ovr_held2",  {31'd0, overrun},   32'd1);

        // ---- priority: frame_start with line_start ----
        pulse_frame(1'b1);
        check("prio_offset",  {28'd0, dl_offset}, 32'd1);
        check("prio_ovr_clr", {31'd0, overrun},   32'd0);
        check("prio_valid",   {31'd0, dl_valid},  32'd0);
        serve_byte("prio_b0", 16'h1820, 8'h8F);

        // ---- abort: ack withheld in FETCH1, then dma_en drops ----
        tick();
        for (int i = 0; i < 3; i++) begin
            check("hold_req",  {31'd0, mem_req},  32'd1);
            check("hold_addr", {16'd0, mem_addr}, 32'h1821);
            tick();
        end
        dma_en = 1'b0;
        tick();
        check("abort_req",    {31'd0, mem_req},   32'd0);
        check("abort_valid",  {31'd0, dl_valid},  32'd0);
        check("abort_offset", {28'd0, dl_offset}, 32'd1);
        check("abort_dl_ptr", {16'd0, dl_ptr},    32'h5000);
        tick();
        check("idle_req", {31'd0, mem_req}, 32'd0);

        // ---- wrap and holey, with a stray ack while mem_req is low ----
        dma_en = 1'b1;
        ZP     = 16'hFFFE;
        pulse_frame(1'b0);
        mem_ack  = 1'b1;
        mem_data = 8'hFF;
        tick();
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        serve_byte("wrap_b0", 16'hFFFE, 8'h61);
        serve_byte("wrap_b1", 16'hFFFF, 8'h12);
        serve_byte("wrap_b2", 16'h0000, 8'h34);
        check("wrap_dl_ptr", {16'd0, dl_ptr},    32'h1234);
        check("wrap_holey",  {30'd0, holey},     32'd3);
        check("wrap_offset", {28'd0, dl_offset}, 32'd1);
        check("wrap_dli",    {31'd0, dli},       32'd0);
        check("wrap_valid",  {31'd0, dl_valid},  32'd1);

        // ---- reset asserted mid-fetch ----
        pulse_line();
        check("wrap_dec", {28'd0, dl_offset}, 32'd0);
        check("wrap_dli0", {31'd0, dli}, 32'd0);
        pulse_line();
        tick();
        check("mid_req",  {31'd0, mem_req},  32'd1);
        check("mid_addr", {16'd0, mem_addr}, 32'h0001);
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_req", {31'd0, mem_req}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
